// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - circular store buffer with youngest-match load forwarding
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          push_byte,
  output logic          full,
  output logic          empty,
  output logic          drain_valid,
  output logic [AW-1:0] drain_addr,
  output logic [DW-1:0] drain_data,
  output logic          drain_byte,
  input  logic          drain_ready,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_hit,
  output logic [DW-1:0] ld_data,
  output logic          ld_stall
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic          byte_q [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;

  logic          push_ok;
  logic          pop;

  assign full        = (count == (PW+1)'(DEPTH));
  assign empty       = (count == '0);
  assign drain_valid = !empty;
  assign drain_addr  = addr_q[head];
  assign drain_data  = data_q[head];
  assign drain_byte  = byte_q[head];

  // A push into a full buffer is dropped even when a pop frees a slot this cycle.
  assign push_ok = push && !full;
  assign pop     = drain_valid && drain_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_ok) tail <= tail + PW'(1);
      if (pop)     head <= head + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      addr_q[tail] <= push_addr;
      data_q[tail] <= push_data;
      byte_q[tail] <= push_byte;
    end
  end

  logic [PW-1:0] lk_idx;
  logic          lk_found;
  logic          lk_byte;
  logic [DW-1:0] lk_data;

  // Walk entries oldest to youngest from head so the last match is the youngest.
  always_comb begin
    lk_idx   = '0;
    lk_found = 1'b0;
    lk_byte  = 1'b0;
    lk_data  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      lk_idx = head + PW'(i);
      if (ld_valid && ((PW+1)'(i) < count) &&
          (addr_q[lk_idx][AW-1:2] == ld_addr[AW-1:2])) begin
        lk_found = 1'b1;
        lk_byte  = byte_q[lk_idx];
        lk_data  = data_q[lk_idx];
      end
    end
  end

  assign ld_hit   = lk_found && !lk_byte;
  assign ld_stall = lk_found && lk_byte;
  assign ld_data  = ld_hit ? lk_data : '0;

endmodule
